cache_control: RTL and testbench

//  Control FSM for the 2-way set-associative L1 data cache with 256-bit lines (lc3b_burst).

---
 rtl/cache_control_pkg.sv | 29 ++
 rtl/cache_control_if.sv | 46 ++++
 rtl/cache_control_lru.sv | 31 +++
 rtl/cache_control.sv | 117 +++++++++++
 tb/tb_cache_control.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_control_pkg.sv
// ---------------------------------------------------------------------------
// cache_control_pkg
//   Shared types and constants for the L1 data cache controller.
//   cache_state_t  : controller FSM states
//   lc3b_set_idx   : set index of the default 8-set cache
//   PMEM_SEL_*     : encodings of pmem_addr_sel
//   way_onehot()   : way number -> one-hot load_way vector
// ---------------------------------------------------------------------------
package cache_control_pkg;

   localparam int unsigned DEF_SET_BITS = 3;

   typedef logic [DEF_SET_BITS-1:0] lc3b_set_idx;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } cache_state_t;

   localparam logic [1:0] PMEM_SEL_CPU  = 2'd0;
   localparam logic [1:0] PMEM_SEL_WAY0 = 2'd1;
   localparam logic [1:0] PMEM_SEL_WAY1 = 2'd2;

   function automatic logic [1:0] way_onehot(input logic way);
      return way ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cache_control_if.sv
// ---------------------------------------------------------------------------
// cache_control_if
//   Signal bundle between the cache controller and its surroundings
//   (CPU port, cache datapath status/controls, physical memory handshake).
//   modport slave  : the controller (cache_control)
//   modport master : the environment driving requests and status
// ---------------------------------------------------------------------------
interface cache_control_if #(
   parameter int unsigned SET_BITS = 3
);
   // CPU side
   logic                mem_read;
   logic                mem_write;
   logic [1:0]          mem_byte_enable;
   logic                mem_resp;
   // datapath status
   logic [SET_BITS-1:0] set_idx;
   logic                hit0;
   logic                hit1;
   logic                dirty0;
   logic                dirty1;
   // datapath controls
   logic [1:0]          load_way;
   logic                data_sel;
   logic                set_dirty;
   logic                clr_dirty;
   logic [1:0]          pmem_addr_sel;
   // physical memory
   logic                pmem_read;
   logic                pmem_write;
   logic                pmem_resp;

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, set_idx,
             hit0, hit1, dirty0, dirty1, pmem_resp,
      output mem_resp, load_way, data_sel, set_dirty, clr_dirty,
             pmem_addr_sel, pmem_read, pmem_write
   );

   modport master (
      output mem_read, mem_write, mem_byte_enable, set_idx,
             hit0, hit1, dirty0, dirty1, pmem_resp,
      input  mem_resp, load_way, data_sel, set_dirty, clr_dirty,
             pmem_addr_sel, pmem_read, pmem_write
   );
endinterface

// File: rtl/cache_control_lru.sv
// ---------------------------------------------------------------------------
// cache_lru
//   One LRU bit per set; bit value = way to evict next.
//   i_rd_idx / o_rd_val      : asynchronous read port
//   i_wr_idx / i_we / i_wr_val: synchronous write port
//   reset clears every bit to 0 (synchronous, active-high).
// ---------------------------------------------------------------------------
module cache_lru #(
   parameter int unsigned SET_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SET_BITS-1:0] i_rd_idx,
   output logic                o_rd_val,
   input  logic [SET_BITS-1:0] i_wr_idx,
   input  logic                i_we,
   input  logic                i_wr_val
);
   localparam int unsigned NUM_SETS = 2**SET_BITS;

   logic [NUM_SETS-1:0] r_lru;

   always_ff @(posedge clk) begin
      if (reset)
         r_lru <= '0;
      else if (i_we)
         r_lru[i_wr_idx] <= i_wr_val;
   end

   assign o_rd_val = r_lru[i_rd_idx];
endmodule

// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//   Control FSM of the 2-way set-associative L1 data cache.
//   Hits complete in the IDLE cycle (write hits merge into the hit way);
//   misses write back a dirty victim, fill the line, then re-evaluate as a hit.
//   Ports: clk, reset (synchronous, active-high), bus (cache_control_if.slave)
// ---------------------------------------------------------------------------
module cache_control
   import cache_control_pkg::*;
#(
   parameter int unsigned SET_BITS = 3
) (
   input  logic          clk,
   input  logic          reset,
   cache_control_if.slave bus
);

   cache_state_t r_state, w_next;
   logic         r_victim, w_victim_next;

   logic w_lru_rd, w_lru_we, w_lru_val;
   logic w_is_write, w_req, w_hit, w_hit_way, w_victim_dirty;

   logic       w_mem_resp, w_data_sel, w_set_dirty, w_clr_dirty;
   logic       w_pmem_read, w_pmem_write;
   logic [1:0] w_load_way, w_pmem_addr_sel;

   cache_lru #(.SET_BITS(SET_BITS)) u_lru (
      .clk      (clk),
      .reset    (reset),
      .i_rd_idx (bus.set_idx),
      .o_rd_val (w_lru_rd),
      .i_wr_idx (bus.set_idx),
      .i_we     (w_lru_we),
      .i_wr_val (w_lru_val)
   );

   // write wins when both request lines are up; hit0 wins over hit1
   assign w_is_write     = bus.mem_write;
   assign w_req          = bus.mem_read | bus.mem_write;
   assign w_hit          = bus.hit0 | bus.hit1;
   assign w_hit_way      = ~bus.hit0 & bus.hit1;
   assign w_victim_dirty = w_lru_rd ? bus.dirty1 : bus.dirty0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_victim <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_victim <= w_victim_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      w_victim_next   = r_victim;
      w_lru_we        = 1'b0;
      w_lru_val       = ~w_hit_way;
      w_mem_resp      = 1'b0;
      w_load_way      = 2'b00;
      w_data_sel      = 1'b0;
      w_set_dirty     = 1'b0;
      w_clr_dirty     = 1'b0;
      w_pmem_addr_sel = PMEM_SEL_CPU;
      w_pmem_read     = 1'b0;
      w_pmem_write    = 1'b0;

      // outputs are held off while reset is high so an abandoned fill
      // cannot load the arrays on a late pmem_resp
      if (!reset) begin
         unique case (r_state)
            IDLE: begin
               if (w_is_write && (bus.mem_byte_enable == 2'b00)) begin
                  w_mem_resp = 1'b1;
               end else if (w_req && w_hit) begin
                  w_mem_resp = 1'b1;
                  w_lru_we   = 1'b1;
                  if (w_is_write) begin
                     w_load_way  = way_onehot(w_hit_way);
                     w_set_dirty = 1'b1;
                  end
               end else if (w_req) begin
                  w_victim_next = w_lru_rd;
                  w_next        = w_victim_dirty ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               w_pmem_write    = 1'b1;
               w_pmem_addr_sel = r_victim ? PMEM_SEL_WAY1 : PMEM_SEL_WAY0;
               if (bus.pmem_resp)
                  w_next = ALLOCATE;
            end
            ALLOCATE: begin
               w_pmem_read = 1'b1;
               if (bus.pmem_resp) begin
                  w_load_way  = way_onehot(r_victim);
                  w_data_sel  = 1'b1;
                  w_clr_dirty = 1'b1;
                  w_next      = IDLE;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   assign bus.mem_resp      = w_mem_resp;
   assign bus.load_way      = w_load_way;
   assign bus.data_sel      = w_data_sel;
   assign bus.set_dirty     = w_set_dirty;
   assign bus.clr_dirty     = w_clr_dirty;
   assign bus.pmem_addr_sel = w_pmem_addr_sel;
   assign bus.pmem_read     = w_pmem_read;
   assign bus.pmem_write    = w_pmem_write;

endmodule

// File: tb/tb_cache_control.sv
// ---------------------------------------------------------------------------
// tb_cache_control
//   Directed bench for cache_control. Inputs change 1 ns after each rising
//   edge; outputs are sampled 3 ns later, before the falling edge.
//   LRU contents are observed through the victim a later dirty miss selects.
// ---------------------------------------------------------------------------
module tb_cache_control;

   logic clk = 1'b0;
   logic reset;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   cache_control_if #(.SET_BITS(3)) bus ();

   cache_control #(.SET_BITS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [9:0] outs;
   assign outs = {bus.mem_resp, bus.load_way, bus.data_sel, bus.set_dirty,
                  bus.clr_dirty, bus.pmem_addr_sel, bus.pmem_read, bus.pmem_write};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_byte_enable = 2'b00;
      bus.set_idx         = 3'd0;
      bus.hit0            = 1'b0;
      bus.hit1            = 1'b0;
      bus.dirty0          = 1'b0;
      bus.dirty1          = 1'b0;
      bus.pmem_resp       = 1'b0;
   endtask

   // Dirty miss on set s with both ways dirty; returns pmem_addr_sel seen in
   // WRITEBACK (1 = way0 victim, 2 = way1 victim), then drains to IDLE.
   task automatic probe_victim(input logic [2:0] s, output logic [1:0] sel);
      cyc(); idle_inputs();
      bus.set_idx = s; bus.mem_read = 1'b1; bus.dirty0 = 1'b1; bus.dirty1 = 1'b1;
      cyc(); #3;
      sel = bus.pmem_addr_sel;
      bus.pmem_resp = 1'b1;
      cyc(); bus.mem_read = 1'b0;
      cyc(); idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      #3;
      n_run++; if (outs !== 10'd0) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, 10'd0); end
   endtask

   task automatic test_read_hit();
      logic [1:0] sel;
      cyc(); idle_inputs();
      bus.set_idx = 3'd3; bus.hit1 = 1'b1; bus.mem_read = 1'b1;
      #3;
      n_run++; if (bus.mem_resp !== 1'b1) begin n_fail++; $display("FAIL rd_hit_resp: got %b want 1", bus.mem_resp); end
      n_run++; if ({bus.pmem_read, bus.pmem_write, bus.load_way} !== 4'b0000) begin n_fail++; $display("FAIL rd_hit_quiet: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.load_way}); end
      probe_victim(3'd3, sel);
      n_run++; if (sel !== 2'd1) begin n_fail++; $display("FAIL rd_hit_lru3: got %0d want 1", sel); end
   endtask

   task automatic test_write_hit();
      logic [1:0] sel;
      cyc(); idle_inputs();
      bus.set_idx = 3'd6; bus.hit0 = 1'b1; bus.mem_write = 1'b1; bus.mem_byte_enable = 2'b10;
      #3;
      n_run++; if ({bus.mem_resp, bus.load_way, bus.data_sel, bus.set_dirty, bus.clr_dirty} !== 6'b101010) begin n_fail++; $display("FAIL wr_hit_ctl: got %b want 101010", {bus.mem_resp, bus.load_way, bus.data_sel, bus.set_dirty, bus.clr_dirty}); end
      probe_victim(3'd6, sel);
      n_run++; if (sel !== 2'd2) begin n_fail++; $display("FAIL wr_hit_lru6: got %0d want 2", sel); end
   endtask

   task automatic test_clean_miss();
      cyc(); idle_inputs();
      bus.set_idx = 3'd5; bus.hit0 = 1'b1; bus.mem_read = 1'b1;
      #3;
      n_run++; if (bus.mem_resp !== 1'b1) begin n_fail++; $display("FAIL cm_prep_resp: got %b want 1", bus.mem_resp); end
      cyc();
      bus.hit0 = 1'b0; bus.dirty0 = 1'b1; bus.dirty1 = 1'b0;
      #3;
      n_run++; if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin n_fail++; $display("FAIL cm_detect: got %b want 000", {bus.mem_resp, bus.pmem_read, bus.pmem_write}); end
      for (int i = 1; i <= 3; i++) begin
         cyc(); #3;
         n_run++; if ({bus.pmem_read, bus.pmem_addr_sel, bus.load_way} !== 5'b10000) begin n_fail++; $display("FAIL cm_fill_%0d: got %b want 10000", i, {bus.pmem_read, bus.pmem_addr_sel, bus.load_way}); end
      end
      cyc();
      bus.pmem_resp = 1'b1;
      #3;
      n_run++; if ({bus.pmem_read, bus.load_way, bus.data_sel, bus.clr_dirty, bus.set_dirty, bus.mem_resp} !== 7'b1101100) begin n_fail++; $display("FAIL cm_load: got %b want 1101100", {bus.pmem_read, bus.load_way, bus.data_sel, bus.clr_dirty, bus.set_dirty, bus.mem_resp}); end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit1 = 1'b1;
      #3;
      n_run++; if ({bus.mem_resp, bus.pmem_read, bus.load_way} !== 4'b1000) begin n_fail++; $display("FAIL cm_resp: got %b want 1000", {bus.mem_resp, bus.pmem_read, bus.load_way}); end
   endtask

   task automatic test_dirty_miss();
      cyc(); idle_inputs();
      bus.set_idx = 3'd2; bus.mem_write = 1'b1; bus.mem_byte_enable = 2'b11; bus.dirty0 = 1'b1;
      #3;
      n_run++; if ({bus.mem_resp, bus.pmem_write, bus.load_way} !== 4'b0000) begin n_fail++; $display("FAIL dm_detect: got %b want 0000", {bus.mem_resp, bus.pmem_write, bus.load_way}); end
      cyc(); #3;
      n_run++; if ({bus.pmem_write, bus.pmem_read, bus.pmem_addr_sel} !== 4'b1001) begin n_fail++; $display("FAIL dm_wb1: got %b want 1001", {bus.pmem_write, bus.pmem_read, bus.pmem_addr_sel}); end
      cyc();
      bus.pmem_resp = 1'b1;
      #3;
      n_run++; if ({bus.pmem_write, bus.pmem_addr_sel, bus.load_way} !== 5'b10100) begin n_fail++; $display("FAIL dm_wb2: got %b want 10100", {bus.pmem_write, bus.pmem_addr_sel, bus.load_way}); end
      cyc();
      bus.pmem_resp = 1'b0; bus.dirty0 = 1'b0; bus.dirty1 = 1'b1; bus.hit1 = 1'b1;
      #3;
      n_run++; if ({bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel} !== 4'b1000) begin n_fail++; $display("FAIL dm_fill: got %b want 1000", {bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel}); end
      cyc();
      bus.pmem_resp = 1'b1;
      #3;
      n_run++; if ({bus.load_way, bus.data_sel, bus.clr_dirty} !== 4'b0111) begin n_fail++; $display("FAIL dm_load_way0: got %b want 0111", {bus.load_way, bus.data_sel, bus.clr_dirty}); end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit1 = 1'b0; bus.hit0 = 1'b1;
      #3;
      n_run++; if ({bus.mem_resp, bus.load_way, bus.data_sel, bus.set_dirty} !== 5'b10101) begin n_fail++; $display("FAIL dm_merge: got %b want 10101", {bus.mem_resp, bus.load_way, bus.data_sel, bus.set_dirty}); end
   endtask

   task automatic test_be_zero();
      logic [1:0] sel;
      cyc(); idle_inputs();
      bus.set_idx = 3'd1; bus.hit1 = 1'b1; bus.mem_write = 1'b1; bus.mem_byte_enable = 2'b00;
      #3;
      n_run++; if ({bus.mem_resp, bus.load_way, bus.set_dirty} !== 4'b1000) begin n_fail++; $display("FAIL be0_ctl: got %b want 1000", {bus.mem_resp, bus.load_way, bus.set_dirty}); end
      probe_victim(3'd1, sel);
      n_run++; if (sel !== 2'd1) begin n_fail++; $display("FAIL be0_lru1: got %0d want 1", sel); end
   endtask

   task automatic test_reset_alloc();
      logic [1:0] sel;
      cyc(); idle_inputs();
      bus.set_idx = 3'd7; bus.hit0 = 1'b1; bus.mem_read = 1'b1;
      cyc();
      bus.set_idx = 3'd4; bus.hit0 = 1'b0; bus.dirty1 = 1'b1;
      cyc(); #3;
      n_run++; if (bus.pmem_read !== 1'b1) begin n_fail++; $display("FAIL ra_fill: got %b want 1", bus.pmem_read); end
      reset = 1'b1; bus.pmem_resp = 1'b1;
      #1;
      n_run++; if ({bus.load_way, bus.clr_dirty} !== 3'b000) begin n_fail++; $display("FAIL ra_noload: got %b want 000", {bus.load_way, bus.clr_dirty}); end
      cyc();
      reset = 1'b0; idle_inputs();
      #3;
      n_run++; if (outs !== 10'd0) begin n_fail++; $display("FAIL ra_idle: got %b want %b", outs, 10'd0); end
      probe_victim(3'd6, sel);
      n_run++; if (sel !== 2'd1) begin n_fail++; $display("FAIL ra_lru6: got %0d want 1", sel); end
      probe_victim(3'd7, sel);
      n_run++; if (sel !== 2'd1) begin n_fail++; $display("FAIL ra_lru7: got %0d want 1", sel); end
   endtask

   task automatic test_drop_wb();
      cyc(); idle_inputs();
      bus.set_idx = 3'd0; bus.mem_read = 1'b1; bus.dirty0 = 1'b1;
      cyc();
      bus.mem_read = 1'b0;
      #3;
      n_run++; if ({bus.pmem_write, bus.pmem_addr_sel} !== 3'b101) begin n_fail++; $display("FAIL drop_wb: got %b want 101", {bus.pmem_write, bus.pmem_addr_sel}); end
      bus.pmem_resp = 1'b1;
      cyc();
      bus.pmem_resp = 1'b0;
      #3;
      n_run++; if (bus.pmem_read !== 1'b1) begin n_fail++; $display("FAIL drop_fill: got %b want 1", bus.pmem_read); end
      cyc();
      bus.pmem_resp = 1'b1;
      #3;
      n_run++; if ({bus.load_way, bus.mem_resp} !== 3'b010) begin n_fail++; $display("FAIL drop_load: got %b want 010", {bus.load_way, bus.mem_resp}); end
      cyc();
      bus.pmem_resp = 1'b0; bus.hit0 = 1'b1;
      #3;
      n_run++; if (outs !== 10'd0) begin n_fail++; $display("FAIL drop_noresp: got %b want %b", outs, 10'd0); end
   endtask

   task automatic test_pmem_resp_idle();
      cyc(); idle_inputs();
      bus.pmem_resp = 1'b1;
      #3;
      n_run++; if (outs !== 10'd0) begin n_fail++; $display("FAIL stray_resp: got %b want %b", outs, 10'd0); end
      cyc();
      bus.pmem_resp = 1'b0;
      #3;
      n_run++; if (outs !== 10'd0) begin n_fail++; $display("FAIL stray_after: got %b want %b", outs, 10'd0); end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_be_zero();
      test_reset_alloc();
      test_drop_wb();
      test_pmem_resp_idle();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
